data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Data memory stage that consumes the CPU core's stage-3 memory request (MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en) and produces MEM_data.
- Contains a word-organised RAM with byte-lane stores and a right-justified load return.
- Adds a small MMIO window: cycle counter, GPIO register, fault status.
- Detects misaligned and out-of-range accesses and records them in a sticky fault register.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, base address of the 16-byte MMIO window.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MEM_addr  in  32  byte address.
- MEM_WR_out  in  32  store data, right-justified.
- MEM_type  in  3  RISC-V funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MEM_rd_en  in  1  load request this cycle.
- MEM_wr_en  in  1  store request this cycle.
- MEM_data  out  32  load data, right-justified, zero-filled above access width. The core performs sign extension.
- gpio_out  out  32  GPIO register contents.
- mem_fault  out  1  sticky fault flag.
- fault_addr  out  32  address of the first faulting access since the fault was last cleared.

Behaviour:
- Reset (Reset=0, asynchronous):
  - gpio_out=0, mem_fault=0, fault_addr=0, cycle counter=0.
  - RAM contents are not reset (undefined).
  - Reset asserted mid-store: the store is dropped.
- Loads:
  - Combinational, zero latency. MEM_data is valid in the same cycle as MEM_rd_en.
  - MEM_data=0 whenever MEM_rd_en=0 or the access faults.
- RAM load decode:
  - word index = MEM_addr[ADDR_W+1:2], where ADDR_W = log2(DEPTH).
  - Byte load returns word >> (8*addr[1:0]) masked to 8 bits.
  - Half load returns word >> (8*addr[1:0]) masked to 16 bits.
  - BU/HU are treated identically to B/H.
- Stores:
  - Committed at the rising CLK edge.
  - Byte lane enables: B = 1 lane at addr[1:0]; H = 2 lanes at addr[1]; W = all 4 lanes.
  - Write data is shifted left by 8*addr[1:0].
  - A load of the same address in the next cycle returns the new data.
- Alignment faults: H with addr[0]=1, or W with addr[1:0]≠0. No write occurs; read returns 0.
- Range:
  - RAM hit when MEM_addr < DEPTH*4.
  - MMIO hit when MEM_addr[31:4]==MMIO_BASE[31:4].
  - Any other address is an out-of-range fault: no write, read returns 0.
- Illegal MEM_type (011, 110, 111) with rd_en or wr_en asserted is a fault.
- MEM_rd_en and MEM_wr_en both high is a fault; the write is suppressed and MEM_data=0.
- MMIO registers (word access only; sub-word MMIO access is a fault):
  - +0x0 CYCLE_LO (RO).
  - +0x4 CYCLE_HI (RO).
  - +0x8 GPIO (RW).
  - +0xC STATUS: read returns {31'b0, mem_fault}; any write clears mem_fault and fault_addr.
  - Writes to RO registers are ignored without a fault.
- Cycle counter: 64-bit, increments every cycle out of reset, wraps 2^64-1 → 0.
- Fault capture: on a faulting access, if mem_fault=0, then mem_fault←1 and fault_addr←MEM_addr at the clock edge. Later faults do not update fault_addr.
- Fault coinciding with a STATUS clear write is impossible, since a STATUS write is itself legal.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined: the MMIO window, cycle counter and GPIO register exist as described above.
- Undefined: no counter or GPIO logic. gpio_out is tied to 0, MMIO addresses are out-of-range faults, and mem_fault can only be cleared by Reset.

Decomposition:
- Shared package holds:
  - mem_size_t encoding (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - MMIO offset constants (MMIO_CYC_LO, MMIO_CYC_HI, MMIO_GPIO, MMIO_STATUS).
- One sub-module, dmem_lane_ctrl (combinational): generates byte enables, shifted write data, load extraction and the misalign flag from addr[1:0] and MEM_type.
- RAM array, MMIO and fault logic stay in data_mem_unit.

Test Plan:
- Store W 0xDEADBEEF @0x10, then load W @0x10 next cycle → MEM_data=0xDEADBEEF; load B @0x13 → 0x000000DE; load H @0x12 → 0x0000DEAD.
- Store B 0x55 @0x11 over the prior word → load W @0x10 = 0xDEAD55EF; other lanes unchanged.
- Load W @0x22 (misaligned) → MEM_data=0, mem_fault=1, fault_addr=0x22; then store W @0x5000 (out of range, DEPTH=1024) → fault_addr stays 0x22 and RAM is unchanged.
- With DMEM_MMIO_EN: write 0x1 to MMIO_BASE+0xC → mem_fault=0, fault_addr=0; write 0xA5A5_0001 to +0x8 → gpio_out=0xA5A50001 next cycle.
- Release Reset, wait 100 cycles, load W MMIO_BASE+0x0 → value within 1 of 100; CYCLE_HI=0. Force the counter to 0xFFFFFFFF_FFFFFFFF → next cycle both halves read 0.
- Assert Reset during a store W @0x0 and with gpio_out=0xFF → gpio_out=0 and mem_fault=0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_unit_pkg
// Shared definitions for the data memory stage:
//   mem_size_t  - RISC-V funct3 load/store size codes
//   MMIO_*      - register offsets inside the 16-byte MMIO window
//   is_legal_type() - true for the five size codes the stage understands
// ---------------------------------------------------------------------------
package data_mem_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  localparam logic [3:0] MMIO_CYC_LO = 4'h0;
  localparam logic [3:0] MMIO_CYC_HI = 4'h4;
  localparam logic [3:0] MMIO_GPIO   = 4'h8;
  localparam logic [3:0] MMIO_STATUS = 4'hC;

  function automatic logic is_legal_type(input logic [2:0] code);
    return (code == MEM_B)  || (code == MEM_H)  || (code == MEM_W) ||
           (code == MEM_BU) || (code == MEM_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_lane_ctrl
// Purely combinational byte-lane steering for one 32-bit memory word.
// Ports:
//   addr_lo   in   2   byte offset within the word (MEM_addr[1:0])
//   mem_type  in   3   funct3 size code
//   wdata     in  32   right-justified store data
//   rword     in  32   word currently held at the addressed RAM location
//   byte_en   out  4   lanes written by a store of this size/offset
//   wdata_sh  out 32   store data moved up to its byte lanes
//   rdata     out 32   load data, right-justified and zero-filled
//   misalign  out  1   half/word access not on its natural boundary
//   illegal   out  1   size code outside the five supported encodings
// ---------------------------------------------------------------------------
module dmem_lane_ctrl
  import data_mem_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);

  logic [4:0]  shamt;
  logic [31:0] rword_sh;

  assign shamt    = {addr_lo, 3'b000};
  assign wdata_sh = wdata << shamt;
  assign rword_sh = rword >> shamt;

  // Signed and unsigned loads share a path: the core does the extension.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    byte_en  = 4'b0000;
    rdata    = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (mem_type)
      MEM_B, MEM_BU: begin
        byte_en = 4'b0001 << addr_lo;
        rdata   = {24'b0, rword_sh[7:0]};
      end
      MEM_H, MEM_HU: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata    = {16'b0, rword_sh[15:0]};
        misalign = addr_lo[0];
      end
      MEM_W: begin
        byte_en  = 4'b1111;
        rdata    = rword;
        misalign = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
// Data memory stage: word-organised RAM with byte-lane stores and a
// zero-latency right-justified load return, an optional MMIO window and a
// sticky fault recorder for misaligned, out-of-range and malformed accesses.
//
// Build option: define DMEM_MMIO_EN to include the MMIO window (64-bit
// cycle counter, GPIO register, STATUS register). Without it gpio_out is 0,
// MMIO addresses fault as out of range and only Reset clears mem_fault.
//
// Parameters:
//   DEPTH      RAM size in 32-bit words (power of two)
//   MMIO_BASE  base byte address of the 16-byte MMIO window
// Ports:
//   CLK         in   1   clock, rising edge
//   Reset       in   1   asynchronous active-low reset
//   MEM_addr    in  32   byte address
//   MEM_WR_out  in  32   store data, right-justified
//   MEM_type    in   3   funct3 size code
//   MEM_rd_en   in   1   load request
//   MEM_wr_en   in   1   store request
//   MEM_data    out 32   load data (0 when idle or faulting)
//   gpio_out    out 32   GPIO register
//   mem_fault   out  1   sticky fault flag
//   fault_addr  out 32   address of the first fault since last clear
// ---------------------------------------------------------------------------
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic [31:0] gpio_out,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);

  localparam int          ADDR_W    = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- decode
  logic              access;
  logic              ram_hit;
  logic              mmio_win;
  logic              mmio_hit;
  logic              fault_now;
  logic              ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram_word;
  logic [31:0]       mmio_rdata;
  logic              status_clr;

  logic [3:0]        byte_en;
  logic [31:0]       wdata_sh;
  logic [31:0]       lane_rdata;
  logic              misalign;
  logic              illegal;

  assign access   = MEM_rd_en | MEM_wr_en;
  assign ram_hit  = {1'b0, MEM_addr} < RAM_BYTES;
  assign mmio_win = MEM_addr[31:4] == MMIO_BASE[31:4];
  assign mmio_hit = mmio_win & MMIO_EN;
  assign ram_idx  = MEM_addr[ADDR_W+1:2];

  // Simultaneous read and write is treated as malformed, as is any MMIO
  // access narrower than a word.
  assign fault_now = access & (illegal | misalign |
                               (MEM_rd_en & MEM_wr_en) |
                               ~(ram_hit | mmio_hit) |
                               (mmio_hit & (MEM_type != MEM_W)));
  assign ok        = access & ~fault_now;
  assign ram_we    = ok & MEM_wr_en & ram_hit;

  dmem_lane_ctrl u_lane_ctrl (
    .addr_lo  (MEM_addr[1:0]),
    .mem_type (MEM_type),
    .wdata    (MEM_WR_out),
    .rword    (ram_word),
    .byte_en  (byte_en),
    .wdata_sh (wdata_sh),
    .rdata    (lane_rdata),
    .misalign (misalign),
    .illegal  (illegal)
  );

  // ------------------------------------------------------------------- RAM
  logic [31:0] mem [DEPTH];

  assign ram_word = mem[ram_idx];

  // NOTE: the storage array has no reset; clearing it would turn the RAM
  // into a register file. Reset instead gates the write enable so a store
  // in flight while Reset is low is dropped.
  always_ff @(posedge CLK) begin
    if (ram_we && Reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[ram_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------ MMIO
`ifdef DMEM_MMIO_EN
  logic [63:0] cycle_cnt;
  logic        mmio_we;

  assign mmio_we    = ok & MEM_wr_en & mmio_hit;
  assign status_clr = mmio_we & (MEM_addr[3:0] == MMIO_STATUS);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt <= '0;
      gpio_out  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (mmio_we && (MEM_addr[3:0] == MMIO_GPIO)) begin
        gpio_out <= MEM_WR_out;
      end
    end
  end

  // Word alignment is already guaranteed here, so only the offset matters.
  always_comb begin
    mmio_rdata = '0;
    case (MEM_addr[3:0])
      MMIO_CYC_LO: mmio_rdata = cycle_cnt[31:0];
      MMIO_CYC_HI: mmio_rdata = cycle_cnt[63:32];
      MMIO_GPIO:   mmio_rdata = gpio_out;
      MMIO_STATUS: mmio_rdata = {31'b0, mem_fault};
      default:     mmio_rdata = '0;
    endcase
  end
`else
  assign gpio_out   = '0;
  assign mmio_rdata = '0;
  assign status_clr = 1'b0;
`endif

  // ------------------------------------------------------------- load path
  always_comb begin
    MEM_data = '0;
    if (ok && MEM_rd_en) begin
      MEM_data = ram_hit ? lane_rdata : mmio_rdata;
    end
  end

  // ------------------------------------------------------- fault recorder
  // Only the first fault is captured; a STATUS write is itself a legal
  // access, so clear and capture never compete in the same cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem_fault  <= 1'b0;
      fault_addr <= '0;
    end else if (status_clr) begin
      mem_fault  <= 1'b0;
      fault_addr <= '0;
    end else if (fault_now && !mem_fault) begin
      mem_fault  <= 1'b1;
      fault_addr <= MEM_addr;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
// Directed bench for data_mem_unit. The driver issues one access per cycle
// and queues the hand-computed response for that cycle; a monitor on the
// falling edge pops each entry and compares MEM_data, fault state and GPIO.
// Define DMEM_MMIO_EN for both bench and RTL to exercise the MMIO window.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        CLK;
  logic        Reset;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic [31:0] MEM_data;
  logic [31:0] gpio_out;
  logic        mem_fault;
  logic [31:0] fault_addr;

  data_mem_unit #(.DEPTH(1024), .MMIO_BASE(BASE)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .MEM_addr   (MEM_addr),
    .MEM_WR_out (MEM_WR_out),
    .MEM_type   (MEM_type),
    .MEM_rd_en  (MEM_rd_en),
    .MEM_wr_en  (MEM_wr_en),
    .MEM_data   (MEM_data),
    .gpio_out   (gpio_out),
    .mem_fault  (mem_fault),
    .fault_addr (fault_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d_lo;
    logic [31:0] d_hi;
    bit          chk_f;
    logic        f;
    logic [31:0] fa;
    bit          chk_g;
    logic [31:0] g;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] lo, input logic [31:0] hi);
    n_cmp++;
    if ($isunknown(act) || act < lo || act > hi) begin
      n_bad++;
      if (lo == hi)
        $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, lo);
      else
        $display("FAIL %s: got 0x%08h expected 0x%08h..0x%08h", name, act, lo, hi);
    end
  endtask

  function automatic exp_t xd(input logic [31:0] d);
    exp_t e;
    e.d_lo = d; e.d_hi = d;
    e.chk_f = 1'b0; e.f = 1'b0; e.fa = '0;
    e.chk_g = 1'b0; e.g = '0;
    return e;
  endfunction

  function automatic exp_t xf(input logic [31:0] d, input logic f, input logic [31:0] fa);
    exp_t e;
    e = xd(d);
    e.chk_f = 1'b1; e.f = f; e.fa = fa;
    return e;
  endfunction

  function automatic exp_t xg(input logic [31:0] d, input logic [31:0] g);
    exp_t e;
    e = xd(d);
    e.chk_g = 1'b1; e.g = g;
    return e;
  endfunction

  // One access per cycle, driven just after the rising edge.
  task automatic op(input logic rd, input logic wr, input logic [2:0] typ,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input exp_t e, input string nm);
    @(posedge CLK);
    #1;
    MEM_rd_en  = rd;
    MEM_wr_en  = wr;
    MEM_type   = typ;
    MEM_addr   = addr;
    MEM_WR_out = wd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check($sformatf("%s/data", nm), MEM_data, e.d_lo, e.d_hi);
      if (e.chk_f) begin
        check($sformatf("%s/fault", nm), {31'b0, mem_fault}, {31'b0, e.f}, {31'b0, e.f});
        check($sformatf("%s/faddr", nm), fault_addr, e.fa, e.fa);
      end
      if (e.chk_g) check($sformatf("%s/gpio", nm), gpio_out, e.g, e.g);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset      = 1'b0;
    MEM_addr   = '0;
    MEM_WR_out = '0;
    MEM_type   = MEM_W;
    MEM_rd_en  = 1'b0;
    MEM_wr_en  = 1'b0;
    #2;
    check("rst/fault", {31'b0, mem_fault}, 32'd0, 32'd0);
    check("rst/faddr", fault_addr, 32'd0, 32'd0);
    check("rst/gpio",  gpio_out,   32'd0, 32'd0);
    check("rst/data",  MEM_data,   32'd0, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // Basic RAM traffic
    op(0, 1, MEM_W,  32'h0000_0000, 32'h1111_1111, xf(0, 0, 0), "st_w_0");
    op(0, 1, MEM_W,  32'h0000_0010, 32'hDEAD_BEEF, xd(0),             "st_w_10");
    op(1, 0, MEM_W,  32'h0000_0010, 32'h0,         xd(32'hDEAD_BEEF), "ld_w_10");
    op(1, 0, MEM_B,  32'h0000_0013, 32'h0,         xd(32'h0000_00DE), "ld_b_13");
    op(1, 0, MEM_BU, 32'h0000_0013, 32'h0,         xd(32'h0000_00DE), "ld_bu_13");
    op(1, 0, MEM_H,  32'h0000_0012, 32'h0,         xd(32'h0000_DEAD), "ld_h_12");
    op(1, 0, MEM_HU, 32'h0000_0010, 32'h0,         xd(32'h0000_BEEF), "ld_hu_10");
    op(0, 1, MEM_B,  32'h0000_0011, 32'hFFFF_FF55, xd(0),             "st_b_11");
    op(1, 0, MEM_W,  32'h0000_0010, 32'h0,         xd(32'hDEAD_55EF), "ld_w_10b");
    op(1, 0, MEM_B,  32'h0000_0011, 32'h0,         xd(32'h0000_0055), "ld_b_11");
    op(0, 1, MEM_H,  32'h0000_0016, 32'hABCD_1234, xd(0),             "st_h_16");
    op(1, 0, MEM_H,  32'h0000_0016, 32'h0,         xd(32'h0000_1234), "ld_h_16");
    op(0, 1, MEM_W,  32'h0000_0FFC, 32'h0BAD_F00D, xd(0),             "st_w_top");
    op(1, 0, MEM_W,  32'h0000_0FFC, 32'h0,         xf(32'h0BAD_F00D, 0, 0), "ld_w_top");

    // Faults: first one is captured, later ones leave fault_addr alone
    op(1, 0, MEM_W,  32'h0000_0022, 32'h0,         xf(0, 0, 0),            "ld_w_mis22");
    op(0, 1, MEM_W,  32'h0000_5000, 32'hCAFE_F00D, xf(0, 1, 32'h22),       "st_w_oor");
    op(1, 0, MEM_W,  32'h0000_0000, 32'h0,         xf(32'h1111_1111, 1, 32'h22), "ld_w_alias0");
    op(1, 0, MEM_W,  32'h0000_1000, 32'h0,         xf(0, 1, 32'h22),       "ld_w_1000");
    op(0, 1, MEM_H,  32'h0000_0011, 32'h0000_9999, xd(0),                  "st_h_mis");
    op(1, 0, MEM_W,  32'h0000_0010, 32'h0,         xd(32'hDEAD_55EF),      "ld_after_mis");
    op(1, 0, 3'b011, 32'h0000_0010, 32'h0,         xd(0),                  "ld_illegal");
    op(0, 1, 3'b011, 32'h0000_0010, 32'h0,         xd(0),                  "st_illegal");
    op(1, 1, MEM_W,  32'h0000_0010, 32'h0,         xd(0),                  "rd_wr_both");
    op(1, 0, MEM_W,  32'h0000_0010, 32'h0,         xf(32'hDEAD_55EF, 1, 32'h22), "ld_after_bad");
    op(1, 0, MEM_H,  32'h0000_0013, 32'h0,         xd(0),                  "ld_h_mis");

`ifdef DMEM_MMIO_EN
    op(1, 0, MEM_W,  BASE + 32'hC, 32'h0,         xd(32'h1),               "rd_status1");
    op(0, 1, MEM_W,  BASE + 32'hC, 32'h1,         xd(0),                   "clr_status");
    op(0, 0, MEM_W,  32'h0,        32'h0,         xf(0, 0, 0),             "after_clr");
    op(0, 1, MEM_W,  BASE + 32'h8, 32'hA5A5_0001, xd(0),                   "wr_gpio");
    op(0, 0, MEM_W,  32'h0,        32'h0,         xg(0, 32'hA5A5_0001),    "gpio_val");
    op(1, 0, MEM_W,  BASE + 32'h8, 32'h0,         xd(32'hA5A5_0001),       "rd_gpio");
    op(1, 0, MEM_W,  BASE + 32'hC, 32'h0,         xd(0),                   "rd_status0");
    op(0, 1, MEM_W,  BASE + 32'h0, 32'h1234_5678, xd(0),                   "wr_ro");
    op(1, 0, MEM_B,  BASE + 32'h8, 32'h0,         xf(0, 0, 0),             "rd_mmio_b");
    op(0, 1, MEM_W,  BASE + 32'h8, 32'h0000_00FF, xf(0, 1, BASE + 32'h8),  "wr_gpio_ff");
    op(0, 0, MEM_W,  32'h0,        32'h0,         xg(0, 32'h0000_00FF),    "gpio_ff");
`else
    op(1, 0, MEM_W,  BASE + 32'h8, 32'h0,         xd(0),                   "rd_nommio");
    op(0, 1, MEM_W,  BASE + 32'h8, 32'hA5A5_0001, xd(0),                   "wr_nommio");
    op(0, 0, MEM_W,  32'h0,        32'h0,         xg(0, 0),                "gpio_tied");
    op(0, 0, MEM_W,  32'h0,        32'h0,         xf(0, 1, 32'h22),        "fault_kept");
`endif

    // Reset in the middle of a store: async clear, store dropped
    @(posedge CLK);
    #1;
    MEM_rd_en  = 1'b0;
    MEM_wr_en  = 1'b1;
    MEM_type   = MEM_W;
    MEM_addr   = 32'h0;
    MEM_WR_out = 32'h7777_7777;
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst/fault", {31'b0, mem_fault}, 32'd0, 32'd0);
    check("async_rst/faddr", fault_addr, 32'd0, 32'd0);
    check("async_rst/gpio",  gpio_out,   32'd0, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    MEM_wr_en = 1'b0;
    Reset     = 1'b1;

`ifdef DMEM_MMIO_EN
    // 99 idle edges plus the edge inside op() give 100 counted cycles
    repeat (99) @(posedge CLK);
    op(1, 0, MEM_W, BASE + 32'h0, 32'h0, xd(0), "cyc_lo_100");
    exp_q[exp_q.size()-1].d_lo = 32'd99;
    exp_q[exp_q.size()-1].d_hi = 32'd101;
    op(1, 0, MEM_W, BASE + 32'h4, 32'h0, xd(0), "cyc_hi_0");
    @(posedge CLK);
    #1;
    MEM_rd_en = 1'b0;
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    op(1, 0, MEM_W, BASE + 32'h0, 32'h0, xd(0), "cyc_wrap_lo");
    op(1, 0, MEM_W, BASE + 32'h4, 32'h0, xd(0), "cyc_wrap_hi");
`endif

    op(1, 0, MEM_W, 32'h0000_0000, 32'h0, xf(32'h1111_1111, 0, 0), "ld_after_rst");
    op(0, 0, MEM_W, 32'h0000_0000, 32'h0, xg(0, 0),                "idle_end");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses never checked", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
